// File: rtl/palindrome_check_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : palindrome_check_scheduler
//  Description : Shares one serial palindrome detector among NREQ requesters.
//                A round-robin arbiter grants one request at a time. For each
//                grant the scheduler clears the detector, shifts the word in
//                MSB first, samples the verdict and returns it tagged with the
//                requester index.
//  Revision    : 1.0 - initial release
// ============================================================================
module palindrome_check_scheduler #(
    parameter int BITS         = 4,
    parameter int NREQ         = 4,
    parameter int RESULT_DELAY = 1,
    // Derived requester-index width; leave at its default.
    parameter int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*BITS-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 det_reset,
    output logic                 det_in,
    input  logic                 det_out,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_pal,
    output logic                 busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNTW  = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int WAITW = $clog2(RESULT_DELAY + 1);

    localparam logic [CNTW-1:0]  c_BIT_LAST  = CNTW'(BITS - 1);
    localparam logic [WAITW-1:0] c_WAIT_LAST = WAITW'(RESULT_DELAY - 1);
    localparam logic [IDW-1:0]   c_ID_LAST   = IDW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_id;
    logic [BITS-1:0]    r_shift;
    logic [CNTW-1:0]    r_bit_cnt;
    logic [WAITW-1:0]   r_wait_cnt;
    logic               r_det_in;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic               r_rsp_pal;
    logic               r_busy;

    // Arbiter results
    logic               w_any;
    logic [IDW-1:0]     w_pick;
    logic [IDW-1:0]     w_ptr_next;
    logic               w_grant;
    int                 w_scan;

    // Round-robin scan starting at r_rr_ptr. The loop runs from the farthest
    // offset down to the nearest so the nearest valid requester wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_scan = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_scan = int'(r_rr_ptr) + i;
            if (w_scan >= NREQ) begin
                w_scan = w_scan - NREQ;
            end
            if (req_valid[w_scan[IDW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_scan[IDW-1:0];
            end
        end
    end

    // Pointer moves to the requester just after the winner, wrapping at NREQ.
    assign w_ptr_next = (w_pick == c_ID_LAST) ? '0 : w_pick + 1'b1;

    // The grant is issued in the same cycle the request is seen in IDLE so the
    // requester's data is captured in the cycle req_ready is high. Reset
    // suppresses it because the capturing edge will be discarded.
    assign w_grant = (r_state == S_IDLE) && w_any && !reset;

    // One-hot grant decode.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_grant && (w_pick == IDW'(i));
        end
    end

    // Detector is held in reset while the block is in reset and for the
    // single CLEAR cycle that precedes every word.
    assign det_reset = reset | (r_state == S_CLEAR);

    // Main scheduler FSM: grant, clear, shift, wait for verdict, respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_det_in    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_pal   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Response is a single-cycle pulse.
            r_rsp_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_det_in <= 1'b0;
                    if (w_any) begin
                        r_shift  <= req_data[int'(w_pick)*BITS +: BITS];
                        r_id     <= w_pick;
                        r_rr_ptr <= w_ptr_next;
                        r_busy   <= 1'b1;
                        r_state  <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    // Present the MSB so it is on det_in in the first SHIFT cycle.
                    r_det_in  <= r_shift[BITS-1];
                    r_shift   <= {r_shift[BITS-2:0], 1'b0};
                    r_bit_cnt <= '0;
                    r_state   <= S_SHIFT;
                end

                S_SHIFT: begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_det_in   <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end else begin
                        r_det_in  <= r_shift[BITS-1];
                        r_shift   <= {r_shift[BITS-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end

                S_WAIT: begin
                    r_det_in <= 1'b0;
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        // Verdict is valid during the final WAIT cycle.
                        r_rsp_pal   <= det_out;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_state     <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign det_in    = r_det_in;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_pal   = r_rsp_pal;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_palindrome_check_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palindrome_check_scheduler
//  Description : Self-checking bench for palindrome_check_scheduler with a
//                behavioural serial palindrome detector attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_palindrome_check_scheduler;

    localparam int BITS         = 4;
    localparam int NREQ         = 4;
    localparam int RESULT_DELAY = 1;
    localparam int IDW          = 2;
    localparam int DW           = NREQ * BITS;
    localparam int LAT          = BITS + RESULT_DELAY + 2;  // grant -> rsp_valid
    localparam int GAP          = LAT + 1;                  // grant -> next grant

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req_valid;
    logic [DW-1:0]   req_data;
    logic [NREQ-1:0] req_ready;
    logic            det_reset;
    logic            det_in;
    logic            det_out;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_pal;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    int m_ptr        = 0;
    int m_idle_from  = 0;
    int m_last_grant = -100;

    typedef struct {
        int   due;
        int   id;
        logic pal;
    } rsp_t;
    rsp_t exp_q[$];

    palindrome_check_scheduler #(
        .BITS         (BITS),
        .NREQ         (NREQ),
        .RESULT_DELAY (RESULT_DELAY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .det_reset (det_reset),
        .det_in    (det_in),
        .det_out   (det_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_pal   (rsp_pal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic is_pal(input logic [BITS-1:0] w);
        logic [BITS-1:0] r;
        r = {<<{w}};
        return (r == w);
    endfunction

    // Behavioural detector: remembers the last BITS serial bits, verdict one
    // cycle after the last bit is shifted in.
    logic [BITS-1:0] det_hist;
    always @(posedge clk) begin
        if (det_reset) det_hist <= '0;
        else           det_hist <= {det_hist[BITS-2:0], det_in};
    end
    assign det_out = is_pal(det_hist);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        req_data  = DW'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            #3;
            n_checks++;
            if (req_ready !== '0 || det_reset !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold: req_ready=%b det_reset=%b, expected 0000 and 1",
                         req_ready, det_reset);
            end
        end
        tick();
        reset     = 1'b0;
        req_valid = '0;
        #3;
        n_checks++;
        if ({req_ready, det_reset, det_in, rsp_valid, rsp_id, rsp_pal, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b dr=%b din=%b rv=%b id=%0d pal=%b busy=%b, expected all 0",
                     req_ready, det_reset, det_in, rsp_valid, rsp_id, rsp_pal, busy);
        end
        m_ptr       = 0;
        m_idle_from = cyc;
    endtask

    // Single request from requester 0 with cycle-accurate checks of the
    // detector drive and response timing.
    task automatic test_single(input logic [BITS-1:0] w, input logic exp_pal);
        req_data              = DW'($urandom);
        req_data[BITS-1:0]    = w;
        req_valid             = 4'b0001;
        #3;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant: req_ready=%b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        req_data  = DW'($urandom);
        #3;
        n_checks++;
        if (det_reset !== 1'b1 || busy !== 1'b1 || det_in !== 1'b0) begin
            n_fail++;
            $display("FAIL single_clear: det_reset=%b busy=%b det_in=%b expected 1 1 0",
                     det_reset, busy, det_in);
        end
        for (int k = 0; k < BITS; k++) begin
            tick();
            #3;
            n_checks++;
            if (det_in !== w[BITS-1-k] || det_reset !== 1'b0) begin
                n_fail++;
                $display("FAIL single_shift%0d: det_in=%b det_reset=%b expected %b 0",
                         k, det_in, det_reset, w[BITS-1-k]);
            end
        end
        for (int d = 0; d < RESULT_DELAY; d++) begin
            tick();
            #3;
            n_checks++;
            if (det_in !== 1'b0 || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_wait: det_in=%b rsp_valid=%b expected 0 0", det_in, rsp_valid);
            end
        end
        tick();
        #3;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== '0 || rsp_pal !== exp_pal || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_resp: rv=%b id=%0d pal=%b busy=%b expected 1 0 %b 1",
                     rsp_valid, rsp_id, rsp_pal, busy, exp_pal);
        end
        tick();
        #3;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_pal !== exp_pal) begin
            n_fail++;
            $display("FAIL single_after: busy=%b rv=%b id=%0d pal=%b expected 0 0 0 %b",
                     busy, rsp_valid, rsp_id, rsp_pal, exp_pal);
        end
        m_ptr       = 1;
        m_idle_from = cyc;
    endtask

    // Serve id2 so the pointer sits at 3, then request 1010: 3 goes first.
    task automatic test_rr_skip();
        req_data  = DW'($urandom);
        req_valid = 4'b0100;
        #3;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL rr_setup: req_ready=%b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (GAP - 1) tick();
        req_valid = 4'b1010;
        #3;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL rr_skip_first: req_ready=%b expected 1000", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        repeat (LAT - 1) tick();
        #3;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin
            n_fail++;
            $display("FAIL rr_skip_rsp: rv=%b id=%0d expected 1 3", rsp_valid, rsp_id);
        end
        tick();
        #3;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL rr_skip_second: req_ready=%b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (GAP - 1) tick();
        m_ptr       = 2;
        m_idle_from = cyc;
    endtask

    // Reset during SHIFT cycle 2 of a word from id1 while the pointer is 2.
    task automatic test_reset_mid();
        req_data  = DW'($urandom);
        req_valid = 4'b0010;
        #3;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL abort_grant: req_ready=%b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        #3;
        n_checks++;
        if ({req_ready, det_in, rsp_valid, rsp_id, rsp_pal, busy} !== '0 || det_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_state: rdy=%b din=%b rv=%b id=%0d pal=%b busy=%b dr=%b expected zeros, dr=1",
                     req_ready, det_in, rsp_valid, rsp_id, rsp_pal, busy, det_reset);
        end
        reset = 1'b0;
        for (int i = 0; i < GAP + 2; i++) begin
            tick();
            #3;
            n_checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet: rv=%b busy=%b expected 0 0", rsp_valid, busy);
            end
        end
        tick();
        req_valid = 4'b0110;
        #3;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL abort_ptr: req_ready=%b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (LAT - 1) tick();
        #3;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
            n_fail++;
            $display("FAIL abort_rsp: rv=%b id=%0d expected 1 1", rsp_valid, rsp_id);
        end
        repeat (2) tick();
        m_ptr       = 2;
        m_idle_from = cyc;
    endtask

    // Traffic against the scoreboard. mode 0: all requesters held high
    // (back-to-back round robin). mode 1: random raise/drop.
    task automatic run_traffic(input int mode, input int ncycles);
        int              granted;
        int              exp_id;
        logic [NREQ-1:0] exp_ready;
        logic            exp_rv;
        logic            exp_busy;
        logic [BITS-1:0] word;
        granted = -1;
        for (int i = 0; i < NREQ; i++) req_data[i*BITS +: BITS] = BITS'($urandom);
        for (int c = 0; c < ncycles; c++) begin
            if (granted >= 0) begin
                req_data[granted*BITS +: BITS] = BITS'($urandom);
                if (mode == 1) req_valid[granted] = 1'($urandom);
            end
            if (c >= ncycles - GAP - 2) begin
                req_valid = '0;
            end else if (mode == 0) begin
                req_valid = '1;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!req_valid[i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            req_data[i*BITS +: BITS] = BITS'($urandom);
                            req_valid[i] = 1'b1;
                        end
                    end else if (i != granted && $urandom_range(0, 7) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            #3;
            exp_ready = '0;
            exp_id    = -1;
            if (cyc >= m_idle_from) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (exp_id < 0 && req_valid[(m_ptr + k) % NREQ]) exp_id = (m_ptr + k) % NREQ;
                end
            end
            if (exp_id >= 0) exp_ready[exp_id] = 1'b1;
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL traffic_grant @%0d: req_ready=%b expected %b", cyc, req_ready, exp_ready);
            end
            granted = exp_id;
            if (exp_id >= 0) begin
                word = req_data[exp_id*BITS +: BITS];
                exp_q.push_back('{due: cyc + LAT, id: exp_id, pal: is_pal(word)});
                m_ptr        = (exp_id + 1) % NREQ;
                m_last_grant = cyc;
                m_idle_from  = cyc + GAP;
            end
            exp_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            n_checks++;
            if (rsp_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL traffic_rv @%0d: rsp_valid=%b expected %b", cyc, rsp_valid, exp_rv);
            end
            if (exp_rv) begin
                n_checks++;
                if (rsp_id !== IDW'(exp_q[0].id) || rsp_pal !== exp_q[0].pal) begin
                    n_fail++;
                    $display("FAIL traffic_rsp @%0d: id=%0d pal=%b expected %0d %b",
                             cyc, rsp_id, rsp_pal, exp_q[0].id, exp_q[0].pal);
                end
                void'(exp_q.pop_front());
            end
            exp_busy = (cyc > m_last_grant) && (cyc < m_last_grant + GAP);
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL traffic_busy @%0d: busy=%b expected %b", cyc, busy, exp_busy);
            end
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL traffic_missing: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        m_idle_from = cyc;
    endtask

    task automatic test_round_robin();
        run_traffic(0, 5 * GAP + GAP + 4);
    endtask

    task automatic test_random_traffic();
        run_traffic(1, 600);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        test_reset();
        test_single(4'b1001, 1'b1);
        test_single(4'b1011, 1'b0);
        test_single(4'b0110, 1'b1);
        test_rr_skip();
        test_reset_mid();
        test_round_robin();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
